// File: rtl/RISCV_pkg.sv
// rtl/RISCV_pkg.sv - shared word type, arbiter state/grant enums and timeout default
package RISCV_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_ACC  = 2'd1,
    FETCH_ACC = 2'd2
  } arb_state_t;

  typedef enum logic {
    G_FETCH = 1'b0,
    G_DATA  = 1'b1
  } grant_t;

  localparam int ACK_TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and data requesters onto one memory port
// Alternates grants under contention and aborts an access whose ack never arrives.
module mem_port_arbiter
  import RISCV_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  if_req,
  input  word_t if_addr,
  output logic  if_done,
  output word_t if_rdata,
  input  logic  dm_rd,
  input  logic  dm_wr,
  input  word_t dm_addr,
  input  word_t dm_wdata,
  output logic  dm_done,
  output word_t dm_rdata,
  output logic  mem_req,
  output logic  mem_we,
  output word_t mem_addr,
  output word_t mem_wdata,
  input  word_t mem_rdata,
  input  logic  mem_ack,
  output logic  bus_err,
  output logic  stall_if,
  output logic  stall_pipe
);

  localparam int CW = $clog2(ACK_TIMEOUT) + 1;

  arb_state_t    state_q, state_d;
  grant_t        last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  word_t         addr_q, addr_d, wdata_q, wdata_d;
  logic          we_q, we_d, ill_q, ill_d;
  logic          if_done_q, if_done_d, dm_done_q, dm_done_d, bus_err_q, bus_err_d;
  word_t         if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

  logic data_pend, fetch_pend, grant_data, grant_fetch, timeout, finish;

  // The requester just completed still holds its request during its done cycle.
  assign data_pend   = (dm_rd | dm_wr) & ~dm_done_q;
  assign fetch_pend  = if_req & ~if_done_q;
  assign grant_data  = data_pend & (~fetch_pend | (last_q == G_FETCH));
  assign grant_fetch = fetch_pend & ~grant_data;
  assign timeout     = ~mem_ack & (cnt_q == CW'(ACK_TIMEOUT - 1));
  assign finish      = mem_ack | timeout;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    ill_d      = ill_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    bus_err_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d = DATA_ACC;
          last_d  = G_DATA;
          cnt_d   = '0;
          addr_d  = dm_addr;
          we_d    = dm_wr;
          wdata_d = dm_wr ? dm_wdata : '0;
          ill_d   = dm_rd & dm_wr;
        end else if (grant_fetch) begin
          state_d = FETCH_ACC;
          last_d  = G_FETCH;
          cnt_d   = '0;
          addr_d  = if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          ill_d   = 1'b0;
        end
      end
      DATA_ACC, FETCH_ACC: begin
        if (finish) begin
          state_d = IDLE;
          addr_d  = '0;
          wdata_d = '0;
          we_d    = 1'b0;
          if (state_q == DATA_ACC) begin
            dm_done_d = 1'b1;
            bus_err_d = ill_q | timeout;
            if (!we_q) dm_rdata_d = timeout ? '0 : mem_rdata;
          end else begin
            if_done_d  = 1'b1;
            bus_err_d  = timeout;
            if_rdata_d = timeout ? '0 : mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= G_FETCH;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      ill_q      <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      ill_q      <= ill_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      bus_err_q  <= bus_err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_req    = (state_q != IDLE);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign if_done    = if_done_q;
  assign dm_done    = dm_done_q;
  assign bus_err    = bus_err_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign stall_if   = if_req & ~if_done_q;
  assign stall_pipe = (dm_rd | dm_wr) & ~dm_done_q;

endmodule
